// File: rtl/npc_fetch_unit_if.sv
// Fetch-unit bus: D-stage control inputs and fetch/RAS outputs.
// master = pipeline side, slave = npc_fetch_unit.
interface npc_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int PERF_W = 16
);
  logic              stall;
  logic              req;
  logic              eret;
  logic [ADDR_W-1:0] epc;
  logic [2:0]        npc_op;
  logic              equal;
  logic [ADDR_W-1:0] pc_d;
  logic [25:0]       imm26;
  logic [ADDR_W-1:0] ra;
  logic [ADDR_W-1:0] pc_f;
  logic [ADDR_W-1:0] pc4_d;
  logic [ADDR_W-1:0] pc8_d;
  logic              fetch_exc;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_valid;
  logic [PERF_W-1:0] ras_hits;
  logic [PERF_W-1:0] ras_misses;

  modport master (
    output stall, req, eret, epc, npc_op,
    output equal, pc_d, imm26, ra,
    input  pc_f, pc4_d, pc8_d, fetch_exc,
    input  ras_top, ras_valid,
    input  ras_hits, ras_misses
  );

  modport slave (
    input  stall, req, eret, epc, npc_op,
    input  equal, pc_d, imm26, ra,
    output pc_f, pc4_d, pc8_d, fetch_exc,
    output ras_top, ras_valid,
    output ras_hits, ras_misses
  );
endinterface

// File: rtl/npc_fetch_unit.sv
// Fetch PC register with redirect priority, AdEL detection and a
// return-address stack with saturating hit/miss counters.
// Ports: clk, reset (sync, active-low), bus (npc_fetch_if.slave).
module npc_fetch_unit #(
  parameter int          ADDR_W     = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC    = 32'h0000_4180,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IMEM_BYTES = 32'h0000_4000,
  parameter int          RAS_DEPTH  = 4,
  parameter int          PERF_W     = 16
) (
  input  logic      clk,
  input  logic      reset,
  npc_fetch_if.slave bus
);
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ADDR_W:0]   wide_t;
  typedef logic [PERF_W-1:0] perf_t;

  typedef enum logic [2:0] {
    OP_SEQ, OP_HOLD, OP_BR, OP_J,
    OP_JAL, OP_JR, OP_JRRA, OP_RSV
  } op_e;

  localparam addr_t RST_A  = addr_t'(RESET_PC);
  localparam addr_t EXC_A  = addr_t'(EXC_VEC);
  localparam addr_t BASE_A = addr_t'(IMEM_BASE);
  // window end kept one bit wider so base+size cannot wrap
  localparam wide_t LIM_A  = wide_t'(BASE_A) + wide_t'(IMEM_BYTES);

  addr_t          fpc_q, fpc_d;
  addr_t          ent_q [RAS_DEPTH];
  addr_t          ent_d [RAS_DEPTH];
  logic [PW-1:0]  ptr_q, ptr_d, ptr_inc, ptr_dec;
  logic [CW-1:0]  cnt_q, cnt_d;
  perf_t          hit_q, hit_d, mis_q, mis_d;
  perf_t          hit_inc, mis_inc;
  addr_t          pc4, pc8, seq, br_off, jtgt;
  op_e            op;

  assign op   = op_e'(bus.npc_op);
  assign pc4  = bus.pc_d + addr_t'(4);
  assign pc8  = bus.pc_d + addr_t'(8);
  assign seq  = fpc_q + addr_t'(4);
  assign jtgt = {bus.pc_d[ADDR_W-1:28], bus.imm26, 2'b00};
  assign br_off = {{(ADDR_W-18){bus.imm26[15]}},
                   bus.imm26[15:0], 2'b00};

  assign ptr_inc = (ptr_q == PW'(RAS_DEPTH-1)) ? '0
                 : ptr_q + PW'(1);
  assign ptr_dec = (ptr_q == '0) ? PW'(RAS_DEPTH-1)
                 : ptr_q - PW'(1);

  assign hit_inc = (hit_q == '1) ? hit_q : hit_q + perf_t'(1);
  assign mis_inc = (mis_q == '1) ? mis_q : mis_q + perf_t'(1);

  always_comb begin
    fpc_d = fpc_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ent_d = ent_q;
    hit_d = hit_q;
    mis_d = mis_q;
    priority case (1'b1)
      bus.req:   fpc_d = EXC_A;
      bus.eret:  fpc_d = bus.epc;
      bus.stall: fpc_d = fpc_q;
      default: begin
        unique case (op)
          OP_SEQ, OP_RSV: fpc_d = seq;
          OP_HOLD:        fpc_d = fpc_q;
          OP_BR:   fpc_d = bus.equal ? pc4 + br_off : seq;
          OP_J:    fpc_d = jtgt;
          OP_JAL: begin
            fpc_d        = jtgt;
            ent_d[ptr_q] = pc8;
            ptr_d        = ptr_inc;
            if (cnt_q != CW'(RAS_DEPTH))
              cnt_d = cnt_q + CW'(1);
          end
          OP_JR:   fpc_d = bus.ra;
          OP_JRRA: begin
            fpc_d = bus.ra;
            if (cnt_q != '0) begin
              if (ent_q[ptr_dec] == bus.ra) hit_d = hit_inc;
              else                          mis_d = mis_inc;
              ptr_d = ptr_dec;
              cnt_d = cnt_q - CW'(1);
            end else begin
              mis_d = mis_inc;
            end
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fpc_q <= RST_A;
      ptr_q <= '0;
      cnt_q <= '0;
      hit_q <= '0;
      mis_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++)
        ent_q[i] <= '0;
    end else begin
      fpc_q <= fpc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      hit_q <= hit_d;
      mis_q <= mis_d;
      ent_q <= ent_d;
    end
  end

  assign bus.pc_f      = fpc_q;
  assign bus.pc4_d     = pc4;
  assign bus.pc8_d     = pc8;
  assign bus.fetch_exc = (fpc_q[1:0] != 2'b00)
                       | (fpc_q < BASE_A)
                       | (wide_t'(fpc_q) >= LIM_A);
  assign bus.ras_valid  = (cnt_q != '0);
  assign bus.ras_top    = (cnt_q != '0) ? ent_q[ptr_dec] : '0;
  assign bus.ras_hits   = hit_q;
  assign bus.ras_misses = mis_q;
endmodule

// File: tb/tb_npc_fetch_unit.sv
// Bench for npc_fetch_unit: directed vector table, RAS/counter
// sequences and a random run against a queue-based reference model.
module tb_npc_fetch_unit;
  localparam int AW = 32;
  localparam int PWID = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  npc_fetch_if #(.ADDR_W(AW), .PERF_W(PWID)) bus ();

  npc_fetch_unit #(
    .ADDR_W(AW), .RAS_DEPTH(DEPTH), .PERF_W(PWID)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  int m_hits, m_miss;

  typedef struct {
    logic rst, stl, rq, er;
    logic [2:0] op;
    logic eq;
    logic [31:0] pcd;
    logic [25:0] imm;
    logic [31:0] r, e;
    logic [31:0] pc, top;
    logic vld;
    logic [15:0] h, m;
    logic exc;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic m_exc(logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < 32'h3000)
        || (pc >= 32'h7000);
  endfunction

  // reference: PC rules in plain arithmetic, RAS as a bounded queue
  task automatic drive(logic rst, logic stl, logic rq, logic er,
                       logic [2:0] op, logic eq, logic [31:0] pcd,
                       logic [25:0] imm, logic [31:0] r,
                       logic [31:0] e);
    logic [31:0] nx;
    reset = rst; bus.stall = stl; bus.req = rq; bus.eret = er;
    bus.npc_op = op; bus.equal = eq; bus.pc_d = pcd;
    bus.imm26 = imm; bus.ra = r; bus.epc = e;
    nx = m_pc;
    if (!rst) begin
      nx = 32'h3000; m_ras.delete(); m_hits = 0; m_miss = 0;
    end else if (rq) nx = 32'h4180;
    else if (er) nx = e;
    else if (!stl) begin
      case (op)
        3'd1: nx = m_pc;
        3'd2: nx = eq ? pcd + 32'd4
                  + 32'($signed(imm[15:0])) * 4 : m_pc + 32'd4;
        3'd3, 3'd4: nx = {pcd[31:28], imm, 2'b00};
        3'd5, 3'd6: nx = r;
        default: nx = m_pc + 32'd4;
      endcase
      if (op == 3'd4) begin
        m_ras.push_back(pcd + 32'd8);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
      if (op == 3'd6) begin
        if (m_ras.size() > 0) begin
          if (m_ras[$] == r) begin
            if (m_hits < 65535) m_hits++;
          end else if (m_miss < 65535) m_miss++;
          void'(m_ras.pop_back());
        end else if (m_miss < 65535) m_miss++;
      end
    end
    m_pc = nx;
    @(posedge clk);
    #1;
  endtask

  task automatic check_model();
    logic [31:0] top;
    top = (m_ras.size() > 0) ? m_ras[$] : 32'h0;
    chk("rnd_pc_f", bus.pc_f, m_pc);
    chk("rnd_ras_top", bus.ras_top, top);
    chk("rnd_ras_valid", 32'(bus.ras_valid),
        32'(m_ras.size() > 0));
    chk("rnd_hits", 32'(bus.ras_hits), 32'(m_hits));
    chk("rnd_misses", 32'(bus.ras_misses), 32'(m_miss));
    chk("rnd_fetch_exc", 32'(bus.fetch_exc), 32'(m_exc(m_pc)));
    chk("rnd_pc4_d", bus.pc4_d, bus.pc_d + 32'd4);
    chk("rnd_pc8_d", bus.pc8_d, bus.pc_d + 32'd8);
  endtask

  initial begin
    logic [31:0] lnk[5];
    logic [31:0] r;
    logic [2:0] op;

    tbl[0]  = '{0,0,0,0,0,0,0,0,0,0,'h3000,0,0,0,0,0};
    tbl[1]  = '{1,0,0,0,0,0,0,0,0,0,'h3004,0,0,0,0,0};
    tbl[2]  = '{1,0,0,0,0,0,0,0,0,0,'h3008,0,0,0,0,0};
    tbl[3]  = '{1,0,0,0,7,0,0,0,0,0,'h300C,0,0,0,0,0};
    tbl[4]  = '{1,0,0,0,2,1,'h3010,'hFFFE,0,0,
                'h300C,0,0,0,0,0};
    tbl[5]  = '{1,0,0,0,2,0,'h3010,'hFFFE,0,0,
                'h3010,0,0,0,0,0};
    tbl[6]  = '{1,0,0,0,4,0,'h3020,'hC10,0,0,
                'h3040,'h3028,1,0,0,0};
    tbl[7]  = '{1,0,0,0,0,0,0,0,0,0,'h3044,'h3028,1,0,0,0};
    tbl[8]  = '{1,0,0,0,6,0,0,0,'h3028,0,'h3028,0,0,1,0,0};
    tbl[9]  = '{1,0,0,0,6,0,0,0,'h3028,0,'h3028,0,0,1,1,0};
    tbl[10] = '{1,0,0,0,4,0,'h3000,'hC40,0,0,
                'h3100,'h3008,1,1,1,0};
    tbl[11] = '{1,1,1,0,3,0,'h3000,0,0,0,
                'h4180,'h3008,1,1,1,0};
    tbl[12] = '{1,0,0,1,4,0,'h3000,'hC40,0,'h3100,
                'h3100,'h3008,1,1,1,0};
    tbl[13] = '{1,1,0,0,4,0,'h3000,'hC40,0,0,
                'h3100,'h3008,1,1,1,0};
    tbl[14] = '{1,0,0,0,1,0,0,0,0,0,'h3100,'h3008,1,1,1,0};
    tbl[15] = '{1,0,0,0,5,0,0,0,'h3002,0,'h3002,'h3008,1,1,1,1};
    tbl[16] = '{1,0,0,0,5,0,0,0,'h2FFC,0,'h2FFC,'h3008,1,1,1,1};
    tbl[17] = '{1,0,0,0,5,0,0,0,'h6FFC,0,'h6FFC,'h3008,1,1,1,0};
    tbl[18] = '{1,0,0,0,5,0,0,0,'h7000,0,'h7000,'h3008,1,1,1,1};
    tbl[19] = '{1,0,0,0,5,0,0,0,'hFFFFFFFC,0,
                'hFFFFFFFC,'h3008,1,1,1,1};
    tbl[20] = '{1,0,0,0,0,0,0,0,0,0,0,'h3008,1,1,1,1};
    tbl[21] = '{0,1,0,0,0,0,0,0,0,0,'h3000,0,0,0,0,0};

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].rst, tbl[i].stl, tbl[i].rq, tbl[i].er,
            tbl[i].op, tbl[i].eq, tbl[i].pcd, tbl[i].imm,
            tbl[i].r, tbl[i].e);
      chk($sformatf("v%0d_pc_f", i), bus.pc_f, tbl[i].pc);
      chk($sformatf("v%0d_top", i), bus.ras_top, tbl[i].top);
      chk($sformatf("v%0d_valid", i), 32'(bus.ras_valid),
          32'(tbl[i].vld));
      chk($sformatf("v%0d_hits", i), 32'(bus.ras_hits),
          32'(tbl[i].h));
      chk($sformatf("v%0d_miss", i), 32'(bus.ras_misses),
          32'(tbl[i].m));
      chk($sformatf("v%0d_exc", i), 32'(bus.fetch_exc),
          32'(tbl[i].exc));
    end

    // five pushes into a four-deep stack: A is overwritten
    drive(0,0,0,0,0,0,0,0,0,0);
    for (int k = 0; k < 5; k++) begin
      lnk[k] = 32'h3108 + 32'(k * 32);
      drive(1,0,0,0,4,0,lnk[k] - 32'd8,26'hC40,0,0);
    end
    chk("ovf_top", bus.ras_top, lnk[4]);
    chk("ovf_valid", 32'(bus.ras_valid), 32'd1);
    for (int k = 4; k >= 1; k--) begin
      drive(1,0,0,0,6,0,0,0,lnk[k],0);
      chk($sformatf("pop%0d_hits", k), 32'(bus.ras_hits),
          32'(5 - k));
    end
    chk("pop_empty", 32'(bus.ras_valid), 32'd0);
    drive(1,0,0,0,6,0,0,0,lnk[0],0);
    chk("lost_a_miss", 32'(bus.ras_misses), 32'd1);
    chk("lost_a_hits", 32'(bus.ras_hits), 32'd4);

    // miss counter saturation
    drive(0,0,0,0,0,0,0,0,0,0);
    for (int k = 0; k < 65535; k++)
      drive(1,0,0,0,6,0,0,0,32'h3000,0);
    chk("sat_reach", 32'(bus.ras_misses), 32'h0000FFFF);
    for (int k = 0; k < 5; k++)
      drive(1,0,0,0,6,0,0,0,32'h3000,0);
    chk("sat_hold", 32'(bus.ras_misses), 32'h0000FFFF);
    chk("sat_hits", 32'(bus.ras_hits), 32'd0);
    drive(0,1,0,0,0,0,0,0,0,0);
    chk("sat_reset", 32'(bus.ras_misses), 32'd0);

    // random run against the model
    for (int k = 0; k < 3000; k++) begin
      op = 3'($urandom_range(0, 7));
      r = 32'h3000 + 32'($urandom_range(0, 4095) * 4);
      if (op == 3'd6 && m_ras.size() > 0
          && $urandom_range(0, 2) != 0)
        r = m_ras[$];
      if ($urandom_range(0, 9) == 0) r = $urandom();
      drive(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 29) == 0),
            op, 1'($urandom_range(0, 1)),
            32'h3000 + 32'($urandom_range(0, 4095) * 4),
            26'($urandom()), r,
            32'h3000 + 32'($urandom_range(0, 4095) * 4));
      check_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/npc_fetch_unit.md
Name: npc_fetch_unit

Overview:
- Parametrised successor to the combinational next-PC logic for the P7 MIPS pipeline.
- Owns the fetch PC register and applies redirect priority: reset > exception request > ERET > stall > D-stage control flow.
- Flags fetch address exceptions (AdEL).
- Adds a return-address stack (RAS) that shadows jal / jr $ra pairs, plus saturating hit/miss counters for performance analysis.

Parameters:
ADDR_W, 32, PC width in bits; must be >= 30.
RESET_PC, 32'h0000_3000, PC value loaded on reset.
EXC_VEC, 32'h0000_4180, handler entry PC taken on req.
IMEM_BASE, 32'h0000_3000, lowest legal fetch address.
IMEM_BYTES, 32'h0000_4000, size of the legal fetch window in bytes.
RAS_DEPTH, 4, number of RAS entries; must be >= 1.
PERF_W, 16, width of the hit/miss counters.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-low (0 = reset), sampled on the rising edge of clk.
stall  in  1  freeze PC and RAS (hazard unit).
req  in  1  exception/interrupt request; redirect to EXC_VEC.
eret  in  1  ERET in D; redirect to epc.
epc  in  ADDR_W  CP0 EPC.
npc_op  in  3  D-stage op: 0 SEQ, 1 HOLD, 2 BR, 3 J, 4 JAL, 5 JR, 6 JR_RA, 7 treated as SEQ.
equal  in  1  branch comparison result (BR taken when 1).
pc_d  in  ADDR_W  PC of the D-stage instruction.
imm26  in  26  instr[25:0]; BR uses imm26[15:0].
ra  in  ADDR_W  forwarded rs value for JR / JR_RA.
pc_f  out  ADDR_W  current fetch PC (registered).
pc4_d  out  ADDR_W  pc_d+4.
pc8_d  out  ADDR_W  pc_d+8 (link value).
fetch_exc  out  1  AdEL on fetch.
ras_top  out  ADDR_W  top RAS entry; 0 when empty.
ras_valid  out  1  RAS non-empty.
ras_hits  out  PERF_W  saturating hit counter.
ras_misses  out  PERF_W  saturating miss counter.

Behaviour:
- Reset (reset==0 at a clock edge):
  - pc_f <= RESET_PC.
  - RAS count, pointer and all entries <= 0.
  - ras_hits, ras_misses <= 0.
  - All other inputs are ignored that cycle.
  - Reset mid-stall or mid-redirect wins unconditionally.
- Next-PC selection on each edge, first match wins:
  - req: EXC_VEC.
  - eret: epc.
  - stall: pc_f (hold).
  - SEQ / op 7: pc_f+4.
  - HOLD: pc_f.
  - BR: pc_d+4+(sext(imm16)<<2) if equal, else pc_f+4.
  - J and JAL: {pc_d[ADDR_W-1:28], imm26, 2'b00}.
  - JR and JR_RA: ra.
- Arithmetic: all adds are modulo 2^ADDR_W; 0xFFFF_FFFC+4 wraps to 0, and the wrap is not an error.
- fetch_exc: combinational from pc_f; 1 iff pc_f[1:0]!=0 or pc_f<IMEM_BASE or pc_f>=IMEM_BASE+IMEM_BYTES. It does not alter PC selection; the pipeline acts on it.
- pc4_d and pc8_d: combinational from pc_d.
- RAS update:
  - Updates only on an "advance" edge: reset==1, req==0, eret==0, stall==0.
  - JAL: push pc_d+8 at top index (ptr); ptr <= (ptr+1) mod RAS_DEPTH; count <= min(count+1, RAS_DEPTH).
  - Push when full overwrites the oldest entry (circular buffer).
  - JR_RA with count>0: if entry[ptr-1]==ra, then ras_hits+1, else ras_misses+1. Then ptr decrements (mod RAS_DEPTH) and count decrements.
  - JR_RA with count==0: ras_misses+1; ptr and count unchanged.
  - JR: does not touch the RAS or the counters.
- Counters saturate at 2^PERF_W-1 and never wrap.
- ras_top = entry[ptr-1] when count>0, else 0. ras_valid = (count!=0).
- Exceptions and ERET leave RAS contents intact; only reset clears them.

Test Plan:
- Reset then release, npc_op=SEQ for 3 cycles -> pc_f: 0x3000, 0x3004, 0x3008, 0x300C; fetch_exc=0; ras_valid=0.
- pc_d=0x3010, npc_op=BR, imm16=0xFFFE -> equal=1 gives pc_f=0x300C next cycle; equal=0 gives pc_f_prev+4.
- JAL at pc_d=0x3020, imm26=0x0000C10 -> pc_f=0x3040, ras_top=0x3028. Later JR_RA with ra=0x3028 -> pc_f=0x3028, ras_hits=1, ras_valid=0. A second JR_RA -> ras_misses=1.
- 5 JALs with RAS_DEPTH=4, link values A..E -> count stays 4, ras_top=E. 4 JR_RAs with ra=E,D,C,B -> ras_hits=4; the first push A is lost.
- stall=1, req=1, npc_op=J in the same cycle -> pc_f=0x4180; RAS unchanged. Next cycle eret=1, epc=0x3100 -> pc_f=0x3100.
- JR with ra=0x3002 -> fetch_exc=1 next cycle. JR with ra=0x2FFC -> fetch_exc=1. 65540 misses with PERF_W=16 -> ras_misses holds 0xFFFF. reset=0 during stall -> pc_f=0x3000 and counters=0.
